pcie_msg_transmitter: RTL and testbench
=======================================

PCIE_MSG_TRANSMITTER -- requirements
Module: pcie_msg_transmitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, AXI/SRAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, SRAM word address width.
REQ-003 SHALL have parameter MAX_FRAG_BEATS, default 8, maximum beats per fragment (power of 2, 1..256).
REQ-004 SHALL have parameter AXI_BASE, default 64'h0, destination base byte address.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cmd_valid / cmd_ready, input / output, 1 / 1, command handshake.
REQ-008 SHALL have port cmd_addr, input, ADDR_WIDTH, SRAM start word of the assembled message.
REQ-009 SHALL have port cmd_len, input, 12, message length in beats.
REQ-010 SHALL have port cmd_tag, input, 4, message tag.
REQ-011 SHALL have port done / done_err, output, 1 / 1, one-cycle completion pulse / error qualifier.
REQ-012 SHALL have AW master ports axi_awvalid (out 1), axi_awready (in 1), axi_awaddr (out 64), axi_awlen (out 8), axi_awsize (out 3), axi_awburst (out 2), axi_awuser (out 64).
REQ-013 SHALL have W master ports axi_wvalid (out 1), axi_wready (in 1), axi_wdata (out DATA_WIDTH), axi_wstrb (out DATA_WIDTH/8), axi_wlast (out 1).
REQ-014 SHALL have B master ports axi_bvalid (in 1), axi_bresp (in 2), axi_bready (out 1).
REQ-015 SHALL have SRAM read ports sram_ren (out 1), sram_raddr (out ADDR_WIDTH), sram_rdata (in DATA_WIDTH); read data valid exactly 1 cycle after sram_ren.

Function
REQ-016 SHALL implement FSM IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE.
REQ-017 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch cmd fields, frag_idx=0; cmd_len==0 -> DONE with done_err=1, no AXI traffic.
REQ-018 Fragment beats = min(MAX_FRAG_BEATS, remaining); last fragment carries the remainder.
REQ-019 AW: axi_awvalid held until awready; awaddr = AXI_BASE + frag_idx*MAX_FRAG_BEATS*(DATA_WIDTH/8); awlen = beats-1; awsize = log2(DATA_WIDTH/8); awburst = 2'b01.
REQ-020 awuser[3:0]=tag, [11:4]=frag_idx, [12]=last-fragment flag, [24:13]=cmd_len, rest 0.
REQ-021 awvalid SHALL rise the cycle after command acceptance; AW and W are not overlapped (W starts after AW handshake).
REQ-022 W: SRAM reads issued only while skid buffer has space; sram_raddr increments per read modulo 2^ADDR_WIDTH (wraps 1023 -> 0).
REQ-023 wdata/wvalid SHALL stay stable under wready=0; no beat lost or duplicated; wstrb all ones; wlast on final beat of each fragment.
REQ-024 Sustained throughput 1 beat/cycle when wready=1; first wvalid no later than 2 cycles after AW handshake.
REQ-025 B: bready=1; on bvalid with bresp==OKAY advance frag_idx, go AW if beats remain, else DONE; bresp!=OKAY -> DONE with done_err=1, remaining fragments dropped.
REQ-026 DONE: done=1 for one cycle, then IDLE; cmd_ready=0 in all states except IDLE.
REQ-027 cmd_valid arriving while busy SHALL be held off (no queuing).

Reset
REQ-028 On rst: FSM=IDLE, skid buffer empty, counters 0; cmd_ready=1; all valid/ready/ren/done/done_err/wlast outputs 0; addr/data outputs 0.
REQ-029 rst mid-transfer SHALL abort immediately; all outputs take reset values on the next cycle, no further handshakes completed.

Configuration
REQ-030 With PCIE_MSG_TX_STATS_EN defined: outputs stat_frag_cnt (32) and stat_err_cnt (16), incremented per OKAY B and per done_err, saturating, cleared by rst.
REQ-031 Without PCIE_MSG_TX_STATS_EN: those ports and counters are absent; all other behaviour identical.

Structure
REQ-032 Shared package pcie_msg_pkg SHALL hold the FSM state enum, the awuser field offsets, and AXI constants (BURST_INCR, RESP_OKAY).
REQ-033 Sub-module pcie_tx_skid_buf (2-entry valid/ready buffer) SHALL absorb the 1-cycle SRAM latency against wready backpressure.

Verification
REQ-034 cmd_addr=0, len=8, MAX=8, wready=1 -> one AW awlen=7, awuser[12]=1; 8 beats data==SRAM[0..7]; done=1, done_err=0.
REQ-035 len=20, MAX=8 -> 3 AWs, awlen 7/7/3, frag_idx 0/1/2, awaddr +0/+256/+512; wlast on beats 8,16,20.
REQ-036 Random wready (50%) on len=13 -> data sequence exact, no gaps lost, stable under stall.
REQ-037 cmd_addr=1020, len=8 -> SRAM reads 1020..1023,0..3.
REQ-038 bresp=2'b10 on fragment 0 of len=16 -> no second AW, done=1 with done_err=1; len=0 -> immediate done_err.
REQ-039 rst asserted mid-W of len=16 -> next cycle all valids 0, cmd_ready=1; a new command completes correctly.

Source files
------------

// File: rtl/pcie_msg_pkg.sv
// Shared definitions for the PCIe message transmitter: FSM encodings, awuser layout, AXI codes.
package pcie_msg_pkg;

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StAw   = 3'd1;
   localparam logic [2:0] StW    = 3'd2;
   localparam logic [2:0] StB    = 3'd3;
   localparam logic [2:0] StDone = 3'd4;

   localparam int unsigned AWUSER_TAG_LSB  = 0;
   localparam int unsigned AWUSER_FRAG_LSB = 4;
   localparam int unsigned AWUSER_LAST_BIT = 12;
   localparam int unsigned AWUSER_LEN_LSB  = 13;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   function automatic logic [63:0] pack_awuser(input logic [3:0]  tag,
                                               input logic [7:0]  frag,
                                               input logic        last,
                                               input logic [11:0] len);
      logic [63:0] u;
      u = '0;
      u[AWUSER_TAG_LSB +: 4]   = tag;
      u[AWUSER_FRAG_LSB +: 8]  = frag;
      u[AWUSER_LAST_BIT]       = last;
      u[AWUSER_LEN_LSB +: 12]  = len;
      return u;
   endfunction

endpackage

// File: rtl/pcie_tx_skid_buf.sv
// Two-entry valid/ready buffer holding SRAM read data until the W channel accepts it.
module pcie_tx_skid_buf
   import pcie_msg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]            count_q, count_d;
   logic                  pop;

   assign out_valid = (count_q != 2'd0);
   assign out_data  = ent0_q;
   assign count     = count_q;

   // Upstream only pushes when it holds a credit, so a push never overflows.
   always_comb begin
      pop     = out_valid && out_ready;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      if (pop) begin
         ent0_d  = ent1_q;
         count_d = count_q - 2'd1;
      end
      if (in_valid) begin
         if (count_d == 2'd0) begin
            ent0_d = in_data;
         end else begin
            ent1_d = in_data;
         end
         count_d = count_d + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pcie_msg_transmitter.sv
// Streams an assembled message from SRAM to AXI as MAX_FRAG_BEATS-sized write bursts.
// Optional statistics counters are built when PCIE_MSG_TX_STATS_EN is defined.
module pcie_msg_transmitter
   import pcie_msg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 256,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned MAX_FRAG_BEATS = 8,
   parameter logic [63:0] AXI_BASE       = 64'h0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [11:0]             cmd_len,
   input  logic [3:0]              cmd_tag,
   output logic                    done,
   output logic                    done_err,
   output logic                    axi_awvalid,
   input  logic                    axi_awready,
   output logic [63:0]             axi_awaddr,
   output logic [7:0]              axi_awlen,
   output logic [2:0]              axi_awsize,
   output logic [1:0]              axi_awburst,
   output logic [63:0]             axi_awuser,
   output logic                    axi_wvalid,
   input  logic                    axi_wready,
   output logic [DATA_WIDTH-1:0]   axi_wdata,
   output logic [DATA_WIDTH/8-1:0] axi_wstrb,
   output logic                    axi_wlast,
   input  logic                    axi_bvalid,
   input  logic [1:0]              axi_bresp,
   output logic                    axi_bready,
   output logic                    sram_ren,
   output logic [ADDR_WIDTH-1:0]   sram_raddr,
   input  logic [DATA_WIDTH-1:0]   sram_rdata
`ifdef PCIE_MSG_TX_STATS_EN
   ,
   output logic [31:0]             stat_frag_cnt,
   output logic [15:0]             stat_err_cnt
`endif
);

   localparam int unsigned StrbW     = DATA_WIDTH / 8;
   localparam logic [11:0] MaxBeats  = 12'(MAX_FRAG_BEATS);
   localparam logic [63:0] FragBytes = 64'(MAX_FRAG_BEATS * StrbW);
   localparam logic [2:0]  AwSize    = 3'($clog2(StrbW));

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [11:0]           len_q, len_d;
   logic [3:0]            tag_q, tag_d;
   logic [11:0]           frag_idx_q, frag_idx_d;
   logic [11:0]           remain_q, remain_d;
   logic [11:0]           rd_left_q, rd_left_d;
   logic [11:0]           wr_left_q, wr_left_d;
   logic                  err_q, err_d;
   logic                  ren_q;

   logic [11:0]           frag_beats;
   logic                  frag_last;
   logic                  in_aw;
   logic                  w_pop;
   logic                  b_ok;
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_data;
   logic [1:0]            skid_cnt;

   pcie_tx_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ren_q),
      .in_data   (sram_rdata),
      .out_valid (skid_valid),
      .out_ready (axi_wready),
      .out_data  (skid_data),
      .count     (skid_cnt)
   );

   always_comb begin
      frag_beats = (remain_q > MaxBeats) ? MaxBeats : remain_q;
      frag_last  = (remain_q <= MaxBeats);
      in_aw      = (state_q == StAw);
      w_pop      = skid_valid && axi_wready;
      // Buffered plus in-flight beats must stay within two after this cycle's pop.
      sram_ren   = (state_q == StW) && (rd_left_q != 12'd0) &&
                   (({1'b0, skid_cnt} + {2'b0, ren_q}) < (3'd2 + {2'b0, w_pop}));
   end

   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      len_d      = len_q;
      tag_d      = tag_q;
      frag_idx_d = frag_idx_q;
      remain_d   = remain_q;
      rd_left_d  = rd_left_q;
      wr_left_d  = wr_left_q;
      err_d      = err_q;
      b_ok       = 1'b0;
      if (sram_ren) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         rd_left_d = rd_left_q - 12'd1;
      end
      if (w_pop) begin
         wr_left_d = wr_left_q - 12'd1;
      end
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               rd_ptr_d   = cmd_addr;
               len_d      = cmd_len;
               remain_d   = cmd_len;
               tag_d      = cmd_tag;
               frag_idx_d = 12'd0;
               err_d      = (cmd_len == 12'd0);
               state_d    = (cmd_len == 12'd0) ? StDone : StAw;
            end
         end
         StAw: begin
            if (axi_awready) begin
               rd_left_d = frag_beats;
               wr_left_d = frag_beats;
               remain_d  = remain_q - frag_beats;
               state_d   = StW;
            end
         end
         StW: begin
            if (w_pop && (wr_left_q == 12'd1)) begin
               state_d = StB;
            end
         end
         StB: begin
            if (axi_bvalid) begin
               if (axi_bresp == RESP_OKAY) begin
                  b_ok       = 1'b1;
                  frag_idx_d = frag_idx_q + 12'd1;
                  state_d    = (remain_q == 12'd0) ? StDone : StAw;
               end else begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         rd_ptr_q   <= '0;
         len_q      <= '0;
         tag_q      <= '0;
         frag_idx_q <= '0;
         remain_q   <= '0;
         rd_left_q  <= '0;
         wr_left_q  <= '0;
         err_q      <= 1'b0;
         ren_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         len_q      <= len_d;
         tag_q      <= tag_d;
         frag_idx_q <= frag_idx_d;
         remain_q   <= remain_d;
         rd_left_q  <= rd_left_d;
         wr_left_q  <= wr_left_d;
         err_q      <= err_d;
         ren_q      <= sram_ren;
      end
   end

   always_comb begin
      cmd_ready   = (state_q == StIdle);
      done        = (state_q == StDone);
      done_err    = (state_q == StDone) && err_q;
      axi_awvalid = in_aw;
      axi_awaddr  = in_aw ? (AXI_BASE + 64'(frag_idx_q) * FragBytes) : '0;
      axi_awlen   = in_aw ? 8'(frag_beats - 12'd1) : '0;
      axi_awsize  = in_aw ? AwSize : '0;
      axi_awburst = in_aw ? BURST_INCR : '0;
      axi_awuser  = in_aw ? pack_awuser(tag_q, frag_idx_q[7:0], frag_last, len_q) : '0;
      axi_wvalid  = skid_valid;
      axi_wdata   = skid_data;
      axi_wstrb   = skid_valid ? '1 : '0;
      axi_wlast   = skid_valid && (wr_left_q == 12'd1);
      axi_bready  = (state_q == StB);
      sram_raddr  = rd_ptr_q;
   end

`ifdef PCIE_MSG_TX_STATS_EN
   logic [31:0] frag_cnt_q, frag_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      frag_cnt_d = frag_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (b_ok && (frag_cnt_q != '1)) begin
         frag_cnt_d = frag_cnt_q + 32'd1;
      end
      if (done_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frag_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         frag_cnt_q <= frag_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign stat_frag_cnt = frag_cnt_q;
   assign stat_err_cnt  = err_cnt_q;
`else
   logic unused_b_ok;
   assign unused_b_ok = b_ok;
`endif

endmodule

// File: tb/tb_pcie_msg_transmitter.sv
// Scoreboard bench: expected AW/W traffic is queued per command and retired by channel monitors.
module tb_pcie_msg_transmitter;

   localparam int DW   = 256;
   localparam int AWD  = 10;
   localparam int MAXB = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid, cmd_ready;
   logic [AWD-1:0]  cmd_addr;
   logic [11:0]     cmd_len;
   logic [3:0]      cmd_tag;
   logic            done, done_err;
   logic            axi_awvalid, axi_awready;
   logic [63:0]     axi_awaddr;
   logic [7:0]      axi_awlen;
   logic [2:0]      axi_awsize;
   logic [1:0]      axi_awburst;
   logic [63:0]     axi_awuser;
   logic            axi_wvalid, axi_wready;
   logic [DW-1:0]   axi_wdata;
   logic [DW/8-1:0] axi_wstrb;
   logic            axi_wlast;
   logic            axi_bvalid;
   logic [1:0]      axi_bresp;
   logic            axi_bready;
   logic            sram_ren;
   logic [AWD-1:0]  sram_raddr;
   logic [DW-1:0]   sram_rdata;

   always #5 clk = ~clk;

   pcie_msg_transmitter #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AWD),
      .MAX_FRAG_BEATS (MAXB),
      .AXI_BASE       (64'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .cmd_tag     (cmd_tag),
      .done        (done),
      .done_err    (done_err),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_awaddr  (axi_awaddr),
      .axi_awlen   (axi_awlen),
      .axi_awsize  (axi_awsize),
      .axi_awburst (axi_awburst),
      .axi_awuser  (axi_awuser),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_wlast   (axi_wlast),
      .axi_bvalid  (axi_bvalid),
      .axi_bresp   (axi_bresp),
      .axi_bready  (axi_bready),
      .sram_ren    (sram_ren),
      .sram_raddr  (sram_raddr),
      .sram_rdata  (sram_rdata)
   );

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
      logic [63:0] user;
   } aw_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } w_t;

   aw_t           aw_q[$];
   w_t            w_q[$];
   logic [DW-1:0] mem [1024];
   int            checks = 0;
   int            errors = 0;
   int            b_pending = 0;
   int            b_idx = 0;
   int            err_frag = -1;
   int            w_hs_cnt = 0;
   bit            wr_rand = 1'b0;
   bit            w_stall_prev = 1'b0;
   bit            aw_stall_prev = 1'b0;
   logic [DW-1:0] w_prev_data;
   logic [63:0]   aw_prev_addr;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SRAM model: one-cycle read latency.
   always @(posedge clk) begin
      if (sram_ren) sram_rdata <= mem[sram_raddr];
   end

   // Slave-side drivers for AW/W/B.
   always @(posedge clk) begin
      #1;
      axi_wready  = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      axi_awready = ($urandom_range(0, 3) != 0);
      axi_bvalid  = (b_pending > 0);
      axi_bresp   = (b_idx == err_frag) ? 2'b10 : 2'b00;
   end

   always @(negedge clk) begin
      if (rst) begin
         w_stall_prev  = 1'b0;
         aw_stall_prev = 1'b0;
      end else begin
         if (aw_stall_prev) begin
            chk("aw_hold_valid", 256'(axi_awvalid), 256'(1));
            chk("aw_hold_addr", 256'(axi_awaddr), 256'(aw_prev_addr));
         end
         aw_stall_prev = axi_awvalid && !axi_awready;
         aw_prev_addr  = axi_awaddr;
         if (w_stall_prev) begin
            chk("w_hold_valid", 256'(axi_wvalid), 256'(1));
            chk("w_hold_data", 256'(axi_wdata), 256'(w_prev_data));
         end
         w_stall_prev = axi_wvalid && !axi_wready;
         w_prev_data  = axi_wdata;
         if (axi_awvalid && axi_awready) begin
            checks++;
            assert (aw_q.size() != 0) else begin
               errors++;
               $error("FAIL aw_unexpected observed=%0h expected=none", axi_awaddr);
            end
            if (aw_q.size() != 0) begin
               aw_t a;
               a = aw_q.pop_front();
               chk("awaddr", 256'(axi_awaddr), 256'(a.addr));
               chk("awlen", 256'(axi_awlen), 256'(a.len));
               chk("awuser", 256'(axi_awuser), 256'(a.user));
               chk("awsize", 256'(axi_awsize), 256'(5));
               chk("awburst", 256'(axi_awburst), 256'(1));
            end
         end
         if (axi_wvalid && axi_wready) begin
            w_hs_cnt++;
            checks++;
            assert (w_q.size() != 0) else begin
               errors++;
               $error("FAIL w_unexpected observed=%0h expected=none", axi_wdata);
            end
            if (w_q.size() != 0) begin
               w_t w;
               w = w_q.pop_front();
               chk("wdata", 256'(axi_wdata), 256'(w.data));
               chk("wlast", 256'(axi_wlast), 256'(w.last));
               chk("wstrb", 256'(axi_wstrb), {224'b0, 32'hFFFF_FFFF});
            end
            if (axi_wlast) b_pending++;
         end
         if (axi_bvalid && axi_bready) begin
            b_pending--;
            b_idx++;
         end
      end
   end

   // Queue the expected traffic, then present the command until accepted.
   task automatic issue(input int addr, input int len, input int tag, input int errf);
      int  rem;
      int  f;
      int  k;
      int  beats;
      bit  accepted;
      aw_t a;
      w_t  w;
      rem      = len;
      f        = 0;
      k        = 0;
      err_frag = errf;
      b_idx    = 0;
      while (rem > 0 && (errf < 0 || f <= errf)) begin
         beats  = (rem > MAXB) ? MAXB : rem;
         a.addr = 64'(f) * 64'(MAXB * DW / 8);
         a.len  = 8'(beats - 1);
         a.user = {39'b0, 12'(len), (rem <= MAXB), 8'(f), 4'(tag)};
         aw_q.push_back(a);
         for (int b = 0; b < beats; b++) begin
            w.data = mem[(addr + k) % 1024];
            w.last = (b == beats - 1);
            w_q.push_back(w);
            k++;
         end
         rem -= beats;
         f++;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = AWD'(addr);
      cmd_len   = 12'(len);
      cmd_tag   = 4'(tag);
      accepted  = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (cmd_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      chk("cmd_accept", 256'(accepted), 256'(1));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("busy_cmd_ready", 256'(cmd_ready), 256'(0));
      chk("awvalid_next", 256'(axi_awvalid), 256'(len > 0));
   endtask

   task automatic wait_done(input logic exp_err);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", 256'(seen), 256'(1));
      if (seen) begin
         chk("done_err", 256'(done_err), 256'(exp_err));
         @(negedge clk);
         chk("done_pulse", 256'(done), 256'(0));
         chk("idle_ready", 256'(cmd_ready), 256'(1));
      end
      chk("aw_left", 256'(aw_q.size()), 256'(0));
      chk("w_left", 256'(w_q.size()), 256'(0));
   endtask

   initial begin
      bit reached;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
      end
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_addr    = '0;
      cmd_len     = '0;
      cmd_tag     = '0;
      axi_awready = 1'b1;
      axi_wready  = 1'b1;
      axi_bvalid  = 1'b0;
      axi_bresp   = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
      chk("rst_awvalid", 256'(axi_awvalid), 256'(0));
      chk("rst_wvalid", 256'(axi_wvalid), 256'(0));
      chk("rst_bready", 256'(axi_bready), 256'(0));
      chk("rst_ren", 256'(sram_ren), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_awaddr", 256'(axi_awaddr), 256'(0));
      chk("rst_wdata", 256'(axi_wdata), 256'(0));
      rst = 1'b0;

      issue(0, 8, 1, -1);      // single full fragment
      wait_done(1'b0);
      issue(100, 20, 5, -1);   // 8/8/4 fragments
      wait_done(1'b0);
      wr_rand = 1'b1;
      issue(200, 13, 9, -1);   // random W backpressure
      wait_done(1'b0);
      issue(1020, 8, 2, -1);   // SRAM address wrap
      wait_done(1'b0);
      wr_rand = 1'b0;
      issue(300, 16, 7, 0);    // SLVERR on first fragment
      wait_done(1'b1);
      issue(50, 0, 3, -1);     // empty message
      wait_done(1'b1);

      // Reset in the middle of a W burst.
      w_hs_cnt = 0;
      issue(400, 16, 4, -1);
      reached = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (w_hs_cnt >= 5) begin
            reached = 1'b1;
            break;
         end
      end
      chk("rst_mid_w_reached", 256'(reached), 256'(1));
      @(posedge clk);
      #1;
      rst       = 1'b1;
      b_pending = 0;
      aw_q.delete();
      w_q.delete();
      @(posedge clk);
      #1;
      chk("abort_awvalid", 256'(axi_awvalid), 256'(0));
      chk("abort_wvalid", 256'(axi_wvalid), 256'(0));
      chk("abort_ren", 256'(sram_ren), 256'(0));
      chk("abort_bready", 256'(axi_bready), 256'(0));
      chk("abort_wlast", 256'(axi_wlast), 256'(0));
      chk("abort_cmd_ready", 256'(cmd_ready), 256'(1));
      rst = 1'b0;
      issue(5, 8, 6, -1);
      wait_done(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
